// File: rtl/cache_pkg.sv
// Shared definitions for the line refill/writeback engine.
//   state_e        : controller FSM states
//   CACHE_T/B      : default tag and byte-offset widths
//   WORDS_PER_LINE : words per line for the default offset width
//   compose_addr() : builds {tag, index, word, 2'b00} for arbitrary field widths
package cache_pkg;

  localparam int unsigned CACHE_T        = 20;
  localparam int unsigned CACHE_B        = 4;
  localparam int unsigned WORDS_PER_LINE = 2 ** (CACHE_B - 2);

  typedef enum logic [2:0] {
    IDLE,
    WB,
    FILL,
    INVAL,
    DONE
  } state_e;

  // Fields arrive zero-extended to 32 bits; the tag lands in the top bits,
  // the index directly above the byte offset, the word just above the byte bits.
  function automatic logic [31:0] compose_addr(input logic [31:0] tag,
                                               input logic [31:0] index,
                                               input logic [31:0] word,
                                               input int unsigned tag_width,
                                               input int unsigned offset_width);
    return (tag << (32 - tag_width)) | (index << offset_width) | (word << 2);
  endfunction

endpackage

// File: rtl/line_refill_ctrl_if.sv
// Word-wide memory beat port.
//   req   : beat request (held across consecutive beats)
//   wen   : 1 = write beat, 0 = read beat
//   addr  : byte address of the word
//   wdata : write-beat data
//   ack   : beat accepted/completed
//   rdata : read data, valid with ack on read beats
// master = refill controller, slave = memory/arbiter.
interface line_refill_ctrl_if;

  logic        req;
  logic        wen;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ack;
  logic [31:0] rdata;

  modport master (
    output req,
    output wen,
    output addr,
    output wdata,
    input  ack,
    input  rdata
  );

  modport slave (
    input  req,
    input  wen,
    input  addr,
    input  wdata,
    output ack,
    output rdata
  );

endinterface

// File: rtl/line_word_counter.sv
// Word counter walking the words of one cache line.
//   clk, reset : clock, asynchronous active-high reset
//   inc        : advance to the next word (wraps after the last word)
//   clear      : force back to word 0 (takes priority over inc)
//   cnt        : current word offset
//   last       : cnt is the last word of the line
module line_word_counter #(
  parameter int unsigned WIDTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clear,
  output logic [WIDTH-1:0] cnt,
  output logic             last
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  // Natural overflow gives the wrap to 0 since the line holds 2^WIDTH words.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign last = (cnt_q == '1);

endmodule

// File: rtl/line_refill_ctrl.sv
// Miss-handling engine for one cache line: writes back a dirty victim word by
// word, then refills the line from memory (or invalidates it on a flush).
//   clk, reset        : clock, asynchronous active-high reset
//   req_*             : request (valid, flush select, tag, set index)
//   req_ready         : engine idle and accepting
//   done              : one-cycle completion pulse
//   line_offset       : word offset presented to the line
//   line_w_en/set_*   : line write port (data, tag, valid, dirty)
//   line_write_data   : word written into the line
//   line_valid/dirty/tag/read_data : current line state and word at line_offset
//   mem               : memory beat port (master side)
module line_refill_ctrl
  import cache_pkg::*;
#(
  parameter int unsigned TAG_WIDTH    = CACHE_T,
  parameter int unsigned OFFSET_WIDTH = CACHE_B,
  parameter int unsigned INDEX_WIDTH  = 32 - TAG_WIDTH - OFFSET_WIDTH
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_valid,
  input  logic                    req_flush,
  input  logic [TAG_WIDTH-1:0]    req_tag,
  input  logic [INDEX_WIDTH-1:0]  req_index,
  output logic                    req_ready,
  output logic                    done,
  output logic [OFFSET_WIDTH-3:0] line_offset,
  output logic                    line_w_en,
  output logic                    line_set_valid,
  output logic                    line_set_dirty,
  output logic [TAG_WIDTH-1:0]    line_set_tag,
  output logic [31:0]             line_write_data,
  input  logic                    line_valid,
  input  logic                    line_dirty,
  input  logic [TAG_WIDTH-1:0]    line_tag,
  input  logic [31:0]             line_read_data,
  line_refill_ctrl_if.master      mem
);

  localparam int unsigned CNT_WIDTH = OFFSET_WIDTH - 2;

  state_e                 state_q, state_d;
  logic [TAG_WIDTH-1:0]   tag_q, victim_tag_q;
  logic [INDEX_WIDTH-1:0] index_q;
  logic                   flush_q;
  logic                   capture;
  logic                   cnt_inc, cnt_clear, cnt_last;
  logic [CNT_WIDTH-1:0]   cnt;

  line_word_counter #(
    .WIDTH (CNT_WIDTH)
  ) u_counter (
    .clk   (clk),
    .reset (reset),
    .inc   (cnt_inc),
    .clear (cnt_clear),
    .cnt   (cnt),
    .last  (cnt_last)
  );

  assign line_offset = cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      tag_q        <= '0;
      victim_tag_q <= '0;
      index_q      <= '0;
      flush_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      if (capture) begin
        tag_q        <= req_tag;
        victim_tag_q <= line_tag;
        index_q      <= req_index;
        flush_q      <= req_flush;
      end
    end
  end

  always_comb begin
    state_d         = state_q;
    capture         = 1'b0;
    cnt_inc         = 1'b0;
    cnt_clear       = 1'b0;
    req_ready       = 1'b0;
    done            = 1'b0;
    line_w_en       = 1'b0;
    line_set_valid  = 1'b0;
    line_set_dirty  = 1'b0;
    line_set_tag    = '0;
    line_write_data = '0;
    mem.req         = 1'b0;
    mem.wen         = 1'b0;
    mem.addr        = '0;
    mem.wdata       = '0;

    unique case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          capture   = 1'b1;
          cnt_clear = 1'b1;
          if (line_valid && line_dirty) begin
            state_d = WB;
          end else if (req_flush) begin
            state_d = INVAL;
          end else begin
            state_d = FILL;
          end
        end
      end

      WB: begin
        mem.req   = 1'b1;
        mem.wen   = 1'b1;
        mem.addr  = compose_addr(32'(victim_tag_q), 32'(index_q), 32'(cnt),
                                 TAG_WIDTH, OFFSET_WIDTH);
        mem.wdata = line_read_data;
        if (mem.ack) begin
          cnt_inc = 1'b1;
          if (cnt_last) begin
            state_d = flush_q ? INVAL : FILL;
          end
        end
      end

      FILL: begin
        mem.req  = 1'b1;
        mem.addr = compose_addr(32'(tag_q), 32'(index_q), 32'(cnt), TAG_WIDTH, OFFSET_WIDTH);
        if (mem.ack) begin
          // Valid only rises with the final word so a partial line never hits.
          line_w_en       = 1'b1;
          line_write_data = mem.rdata;
          line_set_tag    = tag_q;
          line_set_valid  = cnt_last;
          cnt_inc         = 1'b1;
          if (cnt_last) begin
            state_d = DONE;
          end
        end
      end

      INVAL: begin
        // Rewrite word 0 with its own value; only the valid/dirty bits change.
        line_w_en       = 1'b1;
        line_write_data = line_read_data;
        line_set_tag    = victim_tag_q;
        state_d         = DONE;
      end

      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_line_refill_ctrl.sv
module tb_line_refill_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_flush;
  logic [19:0] req_tag;
  logic [7:0]  req_index;
  logic        req_ready;
  logic        done;
  logic [1:0]  line_offset;
  logic        line_w_en;
  logic        line_set_valid;
  logic        line_set_dirty;
  logic [19:0] line_set_tag;
  logic [31:0] line_write_data;
  logic        line_valid;
  logic        line_dirty;
  logic [19:0] line_tag;
  logic [31:0] line_read_data;

  int n_checks = 0;
  int n_errors = 0;

  line_refill_ctrl_if mem_if ();

  line_refill_ctrl #(
    .TAG_WIDTH    (20),
    .OFFSET_WIDTH (4),
    .INDEX_WIDTH  (8)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .req_valid       (req_valid),
    .req_flush       (req_flush),
    .req_tag         (req_tag),
    .req_index       (req_index),
    .req_ready       (req_ready),
    .done            (done),
    .line_offset     (line_offset),
    .line_w_en       (line_w_en),
    .line_set_valid  (line_set_valid),
    .line_set_dirty  (line_set_dirty),
    .line_set_tag    (line_set_tag),
    .line_write_data (line_write_data),
    .line_valid      (line_valid),
    .line_dirty      (line_dirty),
    .line_tag        (line_tag),
    .line_read_data  (line_read_data),
    .mem             (mem_if.master)
  );

  always #5 clk = ~clk;

  // Line storage stand-in: word k reads back as 0xD000000k.
  assign line_read_data = 32'hD000_0000 | 32'(line_offset);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    reset        = 1'b1;
    req_valid    = 1'b0;
    req_flush    = 1'b0;
    req_tag      = '0;
    req_index    = '0;
    line_valid   = 1'b0;
    line_dirty   = 1'b0;
    line_tag     = '0;
    mem_if.ack   = 1'b0;
    mem_if.rdata = '0;

    // Reset state
    #1;
    check("rst_ready", 32'(req_ready), 1);
    check("rst_mem_req", 32'(mem_if.req), 0);
    check("rst_w_en", 32'(line_w_en), 0);
    check("rst_done", 32'(done), 0);
    check("rst_offset", 32'(line_offset), 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Clean refill, tag 0x12345 index 0x0A, zero-wait memory
    req_valid = 1'b1;
    req_tag   = 20'h12345;
    req_index = 8'h0A;
    #1 check("cr_accept_ready", 32'(req_ready), 1);
    @(negedge clk);
    req_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      mem_if.ack   = 1'b1;
      mem_if.rdata = 32'hCAFE_0000 + 32'(k);
      #1;
      check("cr_mem_req", 32'(mem_if.req), 1);
      check("cr_mem_wen", 32'(mem_if.wen), 0);
      check("cr_addr", mem_if.addr, 32'h1234_50A0 + 32'(4 * k));
      check("cr_offset", 32'(line_offset), 32'(k));
      check("cr_w_en", 32'(line_w_en), 1);
      check("cr_wdata", line_write_data, 32'hCAFE_0000 + 32'(k));
      check("cr_set_valid", 32'(line_set_valid), 32'(k == 3));
      check("cr_set_dirty", 32'(line_set_dirty), 0);
      check("cr_set_tag", 32'(line_set_tag), 32'h12345);
      check("cr_ready_busy", 32'(req_ready), 0);
      check("cr_done_early", 32'(done), 0);
      @(negedge clk);
    end
    mem_if.ack = 1'b0;
    #1;
    check("cr_done", 32'(done), 1);
    check("cr_done_mem_req", 32'(mem_if.req), 0);
    check("cr_done_ready", 32'(req_ready), 0);
    @(negedge clk);
    #1;
    check("cr_done_pulse", 32'(done), 0);
    check("cr_idle_ready", 32'(req_ready), 1);

    // Dirty refill with a 3-cycle wait on write beat 1
    line_valid = 1'b1;
    line_dirty = 1'b1;
    line_tag   = 20'h0ABCD;
    req_tag    = 20'h54321;
    req_index  = 8'h0A;
    req_valid  = 1'b1;
    @(negedge clk);
    req_valid  = 1'b0;
    mem_if.ack = 1'b1;
    #1;
    check("dr_wb0_addr", mem_if.addr, 32'h0ABC_D0A0);
    check("dr_wb0_wen", 32'(mem_if.wen), 1);
    check("dr_wb0_wdata", mem_if.wdata, 32'hD000_0000);
    check("dr_wb0_w_en", 32'(line_w_en), 0);
    @(negedge clk);
    for (int w = 0; w < 3; w++) begin
      mem_if.ack = 1'b0;
      #1;
      check("dr_wait_req", 32'(mem_if.req), 1);
      check("dr_wait_addr", mem_if.addr, 32'h0ABC_D0A4);
      check("dr_wait_wdata", mem_if.wdata, 32'hD000_0001);
      check("dr_wait_offset", 32'(line_offset), 1);
      check("dr_wait_w_en", 32'(line_w_en), 0);
      @(negedge clk);
    end
    for (int k = 1; k < 4; k++) begin
      mem_if.ack = 1'b1;
      #1;
      check("dr_wb_addr", mem_if.addr, 32'h0ABC_D0A0 + 32'(4 * k));
      check("dr_wb_wen", 32'(mem_if.wen), 1);
      check("dr_wb_wdata", mem_if.wdata, 32'hD000_0000 + 32'(k));
      check("dr_wb_w_en", 32'(line_w_en), 0);
      check("dr_wb_ready", 32'(req_ready), 0);
      @(negedge clk);
    end
    for (int k = 0; k < 4; k++) begin
      mem_if.ack   = 1'b1;
      mem_if.rdata = 32'hBEEF_0010 + 32'(k);
      #1;
      check("dr_fill_addr", mem_if.addr, 32'h5432_10A0 + 32'(4 * k));
      check("dr_fill_wen", 32'(mem_if.wen), 0);
      check("dr_fill_w_en", 32'(line_w_en), 1);
      check("dr_fill_wdata", line_write_data, 32'hBEEF_0010 + 32'(k));
      check("dr_fill_set_valid", 32'(line_set_valid), 32'(k == 3));
      check("dr_fill_set_tag", 32'(line_set_tag), 32'h54321);
      @(negedge clk);
    end
    mem_if.ack = 1'b0;
    #1 check("dr_done", 32'(done), 1);
    @(negedge clk);

    // Flush of a dirty line: 4 write beats, INVAL, DONE
    line_tag  = 20'h0ABCD;
    req_tag   = 20'h77777;
    req_index = 8'h33;
    req_flush = 1'b1;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      mem_if.ack = 1'b1;
      #1;
      check("fd_wb_addr", mem_if.addr, 32'h0ABC_D330 + 32'(4 * k));
      check("fd_wb_wen", 32'(mem_if.wen), 1);
      check("fd_wb_w_en", 32'(line_w_en), 0);
      @(negedge clk);
    end
    mem_if.ack = 1'b0;
    #1;
    check("fd_inval_w_en", 32'(line_w_en), 1);
    check("fd_inval_valid", 32'(line_set_valid), 0);
    check("fd_inval_dirty", 32'(line_set_dirty), 0);
    check("fd_inval_tag", 32'(line_set_tag), 32'h0ABCD);
    check("fd_inval_data", line_write_data, 32'hD000_0000);
    check("fd_inval_mem_req", 32'(mem_if.req), 0);
    check("fd_inval_done", 32'(done), 0);
    @(negedge clk);
    #1 check("fd_done", 32'(done), 1);
    @(negedge clk);

    // Clean flush with req_valid held high throughout
    line_dirty = 1'b0;
    line_tag   = 20'h13579;
    req_valid  = 1'b1;
    #1 check("cf_accept_ready", 32'(req_ready), 1);
    @(negedge clk);
    line_tag = 20'h0FFFF;
    #1;
    check("cf_inval_w_en", 32'(line_w_en), 1);
    check("cf_inval_tag", 32'(line_set_tag), 32'h13579);
    check("cf_inval_mem_req", 32'(mem_if.req), 0);
    check("cf_inval_ready", 32'(req_ready), 0);
    @(negedge clk);
    #1;
    check("cf_done", 32'(done), 1);
    check("cf_done_ready", 32'(req_ready), 0);
    check("cf_done_w_en", 32'(line_w_en), 0);
    @(negedge clk);
    #1;
    check("cf_idle_ready", 32'(req_ready), 1);
    check("cf_idle_done", 32'(done), 0);
    @(negedge clk);
    req_valid = 1'b0;
    #1 check("cf_second_tag", 32'(line_set_tag), 32'h0FFFF);
    @(negedge clk);
    #1 check("cf_second_done", 32'(done), 1);
    @(negedge clk);

    // Reset in the middle of FILL at word 2
    line_valid = 1'b0;
    req_flush  = 1'b0;
    req_tag    = 20'h12345;
    req_index  = 8'h0A;
    req_valid  = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      mem_if.ack = 1'b1;
      @(negedge clk);
    end
    mem_if.ack = 1'b1;
    #1;
    check("rm_offset_pre", 32'(line_offset), 2);
    check("rm_w_en_pre", 32'(line_w_en), 1);
    #2 reset = 1'b1;
    #1;
    check("rm_mem_req", 32'(mem_if.req), 0);
    check("rm_w_en", 32'(line_w_en), 0);
    check("rm_ready", 32'(req_ready), 1);
    check("rm_offset", 32'(line_offset), 0);
    @(negedge clk);
    reset      = 1'b0;
    mem_if.ack = 1'b0;
    req_tag    = 20'h11111;
    req_valid  = 1'b1;
    @(negedge clk);
    req_valid  = 1'b0;
    mem_if.ack = 1'b1;
    #1;
    check("rm_restart_offset", 32'(line_offset), 0);
    check("rm_restart_addr", mem_if.addr, 32'h1111_10A0);
    check("rm_restart_set_valid", 32'(line_set_valid), 0);
    for (int k = 0; k < 4; k++) @(negedge clk);
    mem_if.ack = 1'b0;
    #1 check("rm_restart_done", 32'(done), 1);
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
